pwm_ramp_driver: RTL and testbench

//  Downstream stage of the partial-ramp start-up FSM. Consumes its one-hot speed levels
//  (out_30/out_50/out_100) and turns them into a slew-limited PWM motor drive.

---
 rtl/fsm_pkg.sv | 38 +++
 rtl/pwm_prescaler.sv | 43 ++++
 rtl/pwm_ramp_driver.sv | 158 +++++++++++++++
 tb/tb_pwm_ramp_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the start-up FSM and its PWM ramp stage:
// state encoding, duty constants and the slew-limited duty step.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    RAMP_DN = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_e;

  localparam logic [6:0] DUTY_0   = 7'd0;
  localparam logic [6:0] DUTY_30  = 7'd30;
  localparam logic [6:0] DUTY_50  = 7'd50;
  localparam logic [6:0] DUTY_100 = 7'd100;

  // Move duty one step toward target without overshooting. Sums are
  // formed in 8 bits so duty+step cannot wrap past 127.
  function automatic logic [6:0] slew_step(input logic [6:0] duty,
                                           input logic [6:0] target,
                                           input logic [6:0] step);
    logic [7:0] up_sum;
    logic [7:0] dn_lim;
    logic [6:0] result;
    up_sum = {1'b0, duty} + {1'b0, step};
    dn_lim = {1'b0, target} + {1'b0, step};
    if (duty < target) begin
      result = (up_sum > {1'b0, target}) ? target : up_sum[6:0];
    end else if (duty > target) begin
      result = ({1'b0, duty} > dn_lim) ? (duty - step) : target;
    end else begin
      result = target;
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk by PRESC: emits a one-clk tick every PRESC enabled clocks.
// The count is frozen (not cleared) while en is low.
module pwm_prescaler #(
  parameter int PRESC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Next prescaler count: advance and wrap while enabled, otherwise hold.
  always_comb begin
    pre_d = pre_q;
    if (en) begin
      if (pre_q == LAST) begin
        pre_d = {PW{1'b0}};
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= {PW{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/pwm_ramp_driver.sv
// Turns the start-up FSM's one-hot speed levels into a slew-limited PWM
// drive. Duty only changes on PWM period boundaries; an invalid level
// combination drops straight into FAULT with duty cleared.
module pwm_ramp_driver
  import fsm_pkg::*;
#(
  parameter int PRESC     = 10,
  parameter int PERIOD    = 100,
  parameter int SLEW_STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       lvl_30,
  input  logic       lvl_50,
  input  logic       lvl_100,
  output logic       pwm_out,
  output logic [6:0] duty,
  output logic       ramping,
  output logic       at_speed,
  output logic       fault
);

  localparam logic [6:0] LAST_CNT = 7'(PERIOD - 1);
  localparam logic [6:0] STEP     = 7'(SLEW_STEP);

  logic       rst_meta_q;
  logic       rst_q;
  logic       tick_s;
  logic       pb_s;
  logic       any_s;
  logic       invalid_s;
  logic [6:0] target_s;
  logic [6:0] new_duty_s;
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] duty_q, duty_d;
  logic       dirty_q, dirty_d;
  logic       pwm_q;
  state_e     state_q, state_d;

  // Reset takes effect immediately but is released two clk edges later,
  // aligned to clk, so no flop sees a release mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  pwm_prescaler #(.PRESC(PRESC)) u_presc (
    .clk   (clk),
    .reset (rst_q),
    .en    (en),
    .tick  (tick_s)
  );

  assign pb_s = tick_s && (cnt_q == LAST_CNT);

  // Decode the level inputs into a target duty and a validity flag.
  always_comb begin
    any_s     = lvl_30 | lvl_50 | lvl_100;
    invalid_s = (lvl_30 & lvl_50) | (lvl_30 & lvl_100) | (lvl_50 & lvl_100);
    case ({lvl_100, lvl_50, lvl_30})
      3'b001:  target_s = DUTY_30;
      3'b010:  target_s = DUTY_50;
      3'b100:  target_s = DUTY_100;
      default: target_s = DUTY_0;
    endcase
  end

  // PWM count: advance on prescaler tick, wrap at the end of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = (cnt_q == LAST_CNT) ? 7'd0 : (cnt_q + 7'd1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM and duty slew. Ramp decisions are taken only on a period boundary,
  // where the new state follows from where the stepped duty landed.
  // In FAULT, dirty records whether any level was high since the last
  // boundary; exit needs one full clean period.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dirty_d    = dirty_q;
    new_duty_s = slew_step(duty_q, target_s, STEP);
    if (invalid_s) begin
      state_d = FAULT;
      duty_d  = DUTY_0;
      dirty_d = 1'b1;
    end else begin
      case (state_q)
        FAULT: begin
          duty_d = DUTY_0;
          if (pb_s) begin
            dirty_d = any_s;
            if (!dirty_q && !any_s) begin
              state_d = IDLE;
            end else begin
              state_d = FAULT;
            end
          end else begin
            dirty_d = dirty_q | any_s;
          end
        end
        IDLE, RAMP_UP, RAMP_DN, HOLD: begin
          if (pb_s) begin
            duty_d = new_duty_s;
            if (new_duty_s == target_s) begin
              state_d = (target_s == DUTY_0) ? IDLE : HOLD;
            end else if (new_duty_s < target_s) begin
              state_d = RAMP_UP;
            end else begin
              state_d = RAMP_DN;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = DUTY_0;
          dirty_d = 1'b0;
        end
      endcase
    end
  end

  // State, duty, count and PWM output registers.
  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q <= IDLE;
      duty_q  <= DUTY_0;
      dirty_q <= 1'b0;
      cnt_q   <= 7'd0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      pwm_q   <= en && (cnt_q < duty_q);
    end
  end

  assign pwm_out  = pwm_q;
  assign duty     = duty_q;
  assign ramping  = (state_q == RAMP_UP) || (state_q == RAMP_DN);
  assign at_speed = (state_q == HOLD) && (duty_q != DUTY_0);
  assign fault    = (state_q == FAULT);

endmodule

// File: tb/tb_pwm_ramp_driver.sv
// Self-checking bench for pwm_ramp_driver: directed scenarios plus a random
// level/enable soak, compared each cycle against a behavioural model.
module tb_pwm_ramp_driver;

  localparam int PRESC  = 2;
  localparam int PERIOD = 100;
  localparam int SLEW   = 10;

  logic       clk;
  logic       reset;
  logic       en;
  logic       lvl_30, lvl_50, lvl_100;
  logic       pwm_out;
  logic [6:0] duty;
  logic       ramping, at_speed, fault;

  int n_checks;
  int n_fail;

  // Behavioural model: counts since release, duty, target seen at last boundary
  int m_hold, m_pre, m_cnt, m_duty, m_goal;
  bit m_fault, m_dirty, m_pwm;

  pwm_ramp_driver #(.PRESC(PRESC), .PERIOD(PERIOD), .SLEW_STEP(SLEW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .lvl_30   (lvl_30),
    .lvl_50   (lvl_50),
    .lvl_100  (lvl_100),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .ramping  (ramping),
    .at_speed (at_speed),
    .fault    (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 2; m_pre = 0; m_cnt = 0; m_duty = 0; m_goal = 0;
    m_fault = 0; m_dirty = 0; m_pwm = 0;
  endtask

  task automatic model_step();
    int  n, tgt;
    bit  tk, pb;
    if (reset) begin
      model_reset();
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      n   = int'(lvl_30) + int'(lvl_50) + int'(lvl_100);
      tgt = lvl_100 ? 100 : (lvl_50 ? 50 : (lvl_30 ? 30 : 0));
      tk  = en && (m_pre == PRESC - 1);
      pb  = tk && (m_cnt == PERIOD - 1);
      m_pwm = en && (m_cnt < m_duty);
      if (en) m_pre = (m_pre + 1) % PRESC;
      if (tk) m_cnt = (m_cnt + 1) % PERIOD;
      if (n >= 2) begin
        m_fault = 1; m_duty = 0; m_dirty = 1; m_goal = 0;
      end else if (m_fault) begin
        if (pb) begin
          if (!m_dirty && n == 0) m_fault = 0;
          m_dirty = (n != 0);
        end else if (n != 0) begin
          m_dirty = 1;
        end
      end else if (pb) begin
        if (tgt > m_duty) m_duty = (m_duty + SLEW > tgt) ? tgt : m_duty + SLEW;
        else if (tgt < m_duty) m_duty = (m_duty - SLEW < tgt) ? tgt : m_duty - SLEW;
        m_goal = tgt;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pwm_out",  {7'd0, pwm_out},  {7'd0, m_pwm});
    chk("duty",     {1'b0, duty},     8'(m_duty));
    chk("fault",    {7'd0, fault},    {7'd0, m_fault});
    chk("ramping",  {7'd0, ramping},  {7'd0, (!m_fault && m_duty != m_goal)});
    chk("at_speed", {7'd0, at_speed}, {7'd0, (!m_fault && m_duty == m_goal && m_duty != 0)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_count_hi(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      hi += int'(pwm_out);
    end
  endtask

  int hi;
  int r;

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; en = 1'b0; lvl_30 = 1'b0; lvl_50 = 1'b0; lvl_100 = 1'b0;
    model_reset();
    run(3);
    chk("rst_duty",  {1'b0, duty}, 8'd0);
    chk("rst_pwm",   {7'd0, pwm_out}, 8'd0);
    chk("rst_fault", {7'd0, fault}, 8'd0);

    // Ramp up from reset to 30
    reset = 1'b0; en = 1'b1; lvl_30 = 1'b1;
    run(205);
    chk("ramp_d10", {1'b0, duty}, 8'd10);
    chk("ramp_rmp", {7'd0, ramping}, 8'd1);
    run(200);
    chk("ramp_d20", {1'b0, duty}, 8'd20);
    run(200);
    chk("ramp_d30", {1'b0, duty}, 8'd30);
    chk("hold_rmp", {7'd0, ramping}, 8'd0);
    chk("hold_spd", {7'd0, at_speed}, 8'd1);
    run_count_hi(200, hi);
    chk("pwm_hi30", 8'(hi), 8'd60);

    // Step up to 100
    lvl_30 = 1'b0; lvl_100 = 1'b1;
    run(1400);
    chk("step_d100", {1'b0, duty}, 8'd100);
    run_count_hi(200, hi);
    chk("pwm_hi100", 8'(hi), 8'd200);

    // Down to 50, then reversal at 70
    lvl_100 = 1'b0; lvl_50 = 1'b1;
    run(1000);
    chk("down_d50", {1'b0, duty}, 8'd50);
    lvl_50 = 1'b0; lvl_100 = 1'b1;
    for (int i = 0; i < 1000 && m_duty != 70; i++) cyc();
    chk("rev_d70", {1'b0, duty}, 8'd70);
    run(50);
    lvl_100 = 1'b0; lvl_50 = 1'b1;
    cyc();
    chk("rev_mid", {1'b0, duty}, 8'd70);
    run(200);
    chk("rev_d60", {1'b0, duty}, 8'd60);
    chk("rev_rmp", {7'd0, ramping}, 8'd1);
    run(200);
    chk("rev_d50", {1'b0, duty}, 8'd50);
    chk("rev_spd", {7'd0, at_speed}, 8'd1);

    // Invalid combination -> fault
    lvl_30 = 1'b1;
    cyc();
    chk("flt_set",  {7'd0, fault}, 8'd1);
    chk("flt_duty", {1'b0, duty}, 8'd0);
    cyc();
    chk("flt_pwm",  {7'd0, pwm_out}, 8'd0);

    // Fault is sticky with a valid level, exits after a clean period
    lvl_30 = 1'b0;
    run(450);
    chk("flt_keep", {7'd0, fault}, 8'd1);
    lvl_50 = 1'b0;
    run(199);
    chk("flt_early", {7'd0, fault}, 8'd1);
    for (int i = 0; i < 400 && m_fault; i++) cyc();
    chk("flt_exit", {7'd0, fault}, 8'd0);

    // Enable low mid-ramp freezes duty and silences pwm
    lvl_30 = 1'b1;
    for (int i = 0; i < 1000 && m_duty != 20; i++) cyc();
    run(30);
    en = 1'b0;
    cyc();
    chk("en_pwm0", {7'd0, pwm_out}, 8'd0);
    run(300);
    chk("en_frz", {1'b0, duty}, 8'd20);
    chk("en_rmp", {7'd0, ramping}, 8'd1);
    en = 1'b1;
    run(600);
    chk("en_res", {1'b0, duty}, 8'd30);

    // Asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1;
    chk("arst_duty", {1'b0, duty}, 8'd0);
    chk("arst_spd",  {7'd0, at_speed}, 8'd0);
    chk("arst_pwm",  {7'd0, pwm_out}, 8'd0);
    model_reset();
    run(3);
    reset = 1'b0;
    run(3);
    chk("arst_after", {1'b0, duty}, 8'd0);

    // Random soak against the model
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        lvl_30 = 1'b1; lvl_50 = 1'($urandom_range(0, 1)); lvl_100 = ~lvl_50;
      end else begin
        r = $urandom_range(0, 3);
        lvl_30 = (r == 1); lvl_50 = (r == 2); lvl_100 = (r == 3);
      end
      en = ($urandom_range(0, 99) < 85);
      run($urandom_range(50, 500));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
